// File: rtl/lsu_amo_unit_pkg.sv
// Shared types and constants for the load/store/AMO unit and its AMO ALU.
// Covers trap causes, load/store funct3 codes, AMO opcodes, FSM states and the decoded instruction.
package lsu_amo_unit_pkg;

    localparam logic [5:0] MCAUSE_LOAD_MISALIGNED  = 6'd4;
    localparam logic [5:0] MCAUSE_STORE_MISALIGNED = 6'd6;
    localparam logic [5:0] MCAUSE_LOAD_PAGE_FAULT  = 6'd13;
    localparam logic [5:0] MCAUSE_STORE_PAGE_FAULT = 6'd15;

    localparam logic [2:0] F3LS_B  = 3'd0;
    localparam logic [2:0] F3LS_H  = 3'd1;
    localparam logic [2:0] F3LS_W  = 3'd2;
    localparam logic [2:0] F3LS_D  = 3'd3;
    localparam logic [2:0] F3LS_BU = 3'd4;
    localparam logic [2:0] F3LS_HU = 3'd5;
    localparam logic [2:0] F3LS_WU = 3'd6;

    // LR and SC share the alu_op field so that one decode path covers every A-extension op.
    localparam logic [3:0] AMO_ADD  = 4'd0;
    localparam logic [3:0] AMO_AND  = 4'd1;
    localparam logic [3:0] AMO_OR   = 4'd2;
    localparam logic [3:0] AMO_XOR  = 4'd3;
    localparam logic [3:0] AMO_MIN  = 4'd4;
    localparam logic [3:0] AMO_MAX  = 4'd5;
    localparam logic [3:0] AMO_MINU = 4'd6;
    localparam logic [3:0] AMO_MAXU = 4'd7;
    localparam logic [3:0] AMO_LR   = 4'd8;
    localparam logic [3:0] AMO_SC   = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        AMO_WR  = 2'd1,
        DONE    = 2'd2,
        SC_FAIL = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic       is_atomic;
        logic       is_swap;
        logic       is_sfence_vma;
        logic [2:0] funct3;
        logic [3:0] alu_op;
        logic       alu_width_32;
    } decoded_inst_t;

endpackage

// File: rtl/lsu_amo_unit_amo_alu.sv
// Combinational read-modify-write ALU for AMOs; W-variants operate on and sign-extend the low 32 bits.
module amo_alu #(
    parameter int XLEN = 64
) (
    input  logic [3:0]      op,
    input  logic            width_32,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);
    import lsu_amo_unit_pkg::*;

    logic            lt_s;
    logic            lt_u;
    logic [XLEN-1:0] r;

    always_comb begin
        lt_s = width_32 ? ($signed(a[31:0]) < $signed(b[31:0])) : ($signed(a) < $signed(b));
        lt_u = width_32 ? (a[31:0] < b[31:0]) : (a < b);
        case (op)
            AMO_ADD:  r = a + b;
            AMO_AND:  r = a & b;
            AMO_OR:   r = a | b;
            AMO_XOR:  r = a ^ b;
            AMO_MIN:  r = lt_s ? a : b;
            AMO_MAX:  r = lt_s ? b : a;
            AMO_MINU: r = lt_u ? a : b;
            AMO_MAXU: r = lt_u ? b : a;
            default:  r = a + b;
        endcase
        y = r;
        if (width_32) begin
            y = XLEN'(r[31:0]);
            if (r[31]) begin
                y = y | ~XLEN'(32'hFFFF_FFFF);
            end
        end
    end

endmodule

// File: rtl/lsu_amo_unit.sv
// MEM stage: drives the D$ for loads, stores and A-extension ops, tracks the LR/SC reservation
// and raises misaligned / page-fault traps with the usual stall/advance/trap pipeline contract.
module lsu_amo_unit
    import lsu_amo_unit_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int RSV_GRAN_BITS = 6,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  decoded_inst_t   inst,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic            is_bubble,
    input  logic            op_trapped,
    input  logic            advance,
    input  logic            rsv_kill,
    output logic            stall,
    output logic [XLEN-1:0] rdata,
    output logic            force_pipeline_flush,
    output logic            tlb_invalidate,
    output logic            gen_trap,
    output logic [XLEN-1:0] gen_trap_cause,
    output logic [XLEN-1:0] gen_trap_val,
    output logic            dc_en,
    output logic            dc_write_en,
    output logic [XLEN-1:0] dc_in_addr,
    output logic [XLEN-1:0] dc_in_wdata,
    output logic [1:0]      dc_in_wlen,
    input  logic [XLEN-1:0] dc_out_rdata,
    input  logic            dc_out_rvalid,
    input  logic            dc_out_write_done,
    input  logic            dc_out_page_fault
);

    localparam int OFF_W = $clog2(XLEN / 8);

    lsu_state_t      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            rsv_valid_q, rsv_valid_d;
    logic [XLEN-1:0] rsv_addr_q, rsv_addr_d;

    logic            live;
    logic            is_lr;
    logic            is_sc;
    logic            plain_load;
    logic            plain_store;
    logic            mem_op;
    logic            load_like;
    logic            misaligned;
    logic            granule_match;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] size_mask;
    logic            sign_bit;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] alu_result;

    logic            stall_c;
    logic            dc_en_c;
    logic            dc_we_c;
    logic            trap_c;
    logic [5:0]      cause_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] rdata_c;

    assign live          = !is_bubble && !op_trapped;
    assign is_lr         = inst.is_atomic && (inst.alu_op == AMO_LR);
    assign is_sc         = inst.is_atomic && (inst.alu_op == AMO_SC);
    assign plain_load    = inst.is_load && !inst.is_atomic;
    assign plain_store   = inst.is_store && !inst.is_atomic;
    assign mem_op        = plain_load || plain_store || inst.is_atomic;
    assign load_like     = plain_load || is_lr;
    assign granule_match = (ex_addr >> RSV_GRAN_BITS) == rsv_addr_q;

    always_comb begin
        case (inst.funct3[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = ex_addr[0];
            2'd2:    misaligned = |ex_addr[1:0];
            default: misaligned = |ex_addr[2:0];
        endcase
    end

    // The D$ returns the whole aligned word; bring the addressed bytes down, then extend.
    always_comb begin
        shifted = dc_out_rdata >> {ex_addr[OFF_W-1:0], 3'b000};
        case (inst.funct3[1:0])
            2'd0: begin
                size_mask = XLEN'(32'h0000_00FF);
                sign_bit  = shifted[7];
            end
            2'd1: begin
                size_mask = XLEN'(32'h0000_FFFF);
                sign_bit  = shifted[15];
            end
            2'd2: begin
                size_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                size_mask = '1;
                sign_bit  = 1'b0;
            end
        endcase
        load_data = shifted & size_mask;
        if (!inst.funct3[2] && sign_bit) begin
            load_data = load_data | ~size_mask;
        end
    end

    amo_alu #(
        .XLEN(XLEN)
    ) u_amo_alu (
        .op       (inst.alu_op),
        .width_32 (inst.alu_width_32),
        .a        (result_q),
        .b        (ex_wdata),
        .y        (alu_result)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        rsv_valid_d = rsv_valid_q;
        rsv_addr_d  = rsv_addr_q;
        stall_c     = 1'b0;
        dc_en_c     = 1'b0;
        dc_we_c     = 1'b0;
        trap_c      = 1'b0;
        cause_c     = '0;
        wdata_c     = ex_wdata;
        rdata_c     = result_q;

        case (state_q)
            IDLE: begin
                rdata_c = load_data;
                if (live && mem_op) begin
                    if (MISALIGN_TRAP && misaligned) begin
                        trap_c  = 1'b1;
                        cause_c = load_like ? MCAUSE_LOAD_MISALIGNED : MCAUSE_STORE_MISALIGNED;
                    end else if (plain_load) begin
                        dc_en_c = 1'b1;
                        if (dc_out_page_fault) begin
                            trap_c  = 1'b1;
                            cause_c = MCAUSE_LOAD_PAGE_FAULT;
                        end else begin
                            stall_c = !dc_out_rvalid;
                        end
                    end else if (plain_store) begin
                        dc_en_c = 1'b1;
                        dc_we_c = 1'b1;
                        if (dc_out_page_fault) begin
                            trap_c  = 1'b1;
                            cause_c = MCAUSE_STORE_PAGE_FAULT;
                        end else if (dc_out_write_done) begin
                            if (granule_match) begin
                                rsv_valid_d = 1'b0;
                            end
                        end else begin
                            stall_c = 1'b1;
                        end
                    end else if (is_sc) begin
                        // Reservation is only dropped once the SC outcome is decided.
                        if (rsv_valid_q && granule_match) begin
                            dc_en_c = 1'b1;
                            dc_we_c = 1'b1;
                            if (dc_out_page_fault) begin
                                trap_c      = 1'b1;
                                cause_c     = MCAUSE_STORE_PAGE_FAULT;
                                rsv_valid_d = 1'b0;
                            end else begin
                                stall_c = 1'b1;
                                if (dc_out_write_done) begin
                                    result_d    = '0;
                                    rsv_valid_d = 1'b0;
                                    state_d     = DONE;
                                end
                            end
                        end else begin
                            stall_c     = 1'b1;
                            result_d    = XLEN'(1);
                            rsv_valid_d = 1'b0;
                            state_d     = SC_FAIL;
                        end
                    end else begin
                        dc_en_c = 1'b1;
                        if (dc_out_page_fault) begin
                            trap_c  = 1'b1;
                            cause_c = is_lr ? MCAUSE_LOAD_PAGE_FAULT : MCAUSE_STORE_PAGE_FAULT;
                        end else begin
                            stall_c = 1'b1;
                            if (dc_out_rvalid) begin
                                result_d = load_data;
                                if (is_lr) begin
                                    rsv_valid_d = 1'b1;
                                    rsv_addr_d  = ex_addr >> RSV_GRAN_BITS;
                                    state_d     = DONE;
                                end else begin
                                    state_d = AMO_WR;
                                end
                            end
                        end
                    end
                end
            end

            AMO_WR: begin
                dc_en_c = 1'b1;
                dc_we_c = 1'b1;
                wdata_c = inst.is_swap ? ex_wdata : alu_result;
                if (dc_out_page_fault) begin
                    trap_c  = 1'b1;
                    cause_c = MCAUSE_STORE_PAGE_FAULT;
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (dc_out_write_done) begin
                        state_d = DONE;
                        if (granule_match) begin
                            rsv_valid_d = 1'b0;
                        end
                    end
                end
            end

            DONE, SC_FAIL: begin
                if (advance) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        if (rsv_kill) begin
            rsv_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            rsv_valid_q <= 1'b0;
            rsv_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            rsv_valid_q <= rsv_valid_d;
            rsv_addr_q  <= rsv_addr_d;
        end
    end

    assign stall                = stall_c && !reset;
    assign dc_en                = dc_en_c && !reset;
    assign dc_write_en          = dc_we_c && !reset;
    assign gen_trap             = trap_c && !reset;
    assign gen_trap_cause       = XLEN'(cause_c);
    assign gen_trap_val         = ex_addr;
    assign rdata                = rdata_c;
    assign dc_in_addr           = ex_addr;
    assign dc_in_wdata          = wdata_c;
    assign dc_in_wlen           = inst.funct3[1:0];
    assign force_pipeline_flush = live && inst.is_sfence_vma;
    assign tlb_invalidate       = live && inst.is_sfence_vma;

endmodule
